// File: rtl/lcd_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lcd_pkg: shared constants, FSM encoding and DDRAM address helper.
// Rev 1.0
// ----------------------------------------------------------------------------
package lcd_pkg;

    localparam int         RS_BIT            = 8;
    localparam logic [8:0] LCD_CMD_CLEAR     = 9'h001;
    localparam logic [8:0] LCD_CMD_SET_DDRAM = 9'h080;
    localparam logic [7:0] ROW_BASE_ODD      = 8'h40;

    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_FF  = 8'h0C;
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] PRINT_MIN = 8'h20;
    localparam logic [7:0] PRINT_MAX = 8'h7E;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_CHAR = 2'd2,
        ST_CMD  = 2'd3
    } lcd_state_e;

    // Odd rows live at 0x40; rows 2/3 continue after COLS cells of rows 0/1.
    function automatic logic [6:0] ddram_addr(input int unsigned row, input int unsigned cols);
        int unsigned a;
        a = (row % 2) * 32'(ROW_BASE_ODD) + (row / 2) * cols;
        return 7'(a);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_char_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lcd_char_fifo: byte-wide synchronous FIFO with full/empty flags.
// Rev 1.0
// ----------------------------------------------------------------------------
module lcd_char_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        push_ok, pop_ok;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule
`default_nettype wire

// File: rtl/lcd_char_stream.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lcd_char_stream: buffered ASCII to HD44780 instruction sequencer with cursor.
// Optional build macro LCD_CASE_FOLD_EN folds a-z to A-Z.  Rev 1.0
// ----------------------------------------------------------------------------
module lcd_char_stream
    import lcd_pkg::*;
#(
    parameter  int COLS       = 16,
    parameter  int ROWS       = 2,
    parameter  int FIFO_DEPTH = 8,
    localparam int ROW_W      = ($clog2(ROWS) > 0) ? $clog2(ROWS) : 1,
    localparam int COL_W      = $clog2(COLS + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             char_valid,
    input  logic [7:0]       char,
    output logic             char_ready,
    output logic             instr_valid,
    output logic [8:0]       instr,
    input  logic             instr_ready,
    output logic [ROW_W-1:0] cur_row,
    output logic [COL_W-1:0] cur_col
);
    lcd_state_e       state_q, state_d;
    logic [7:0]       byte_q, byte_d;
    logic             have_q, have_d;
    logic             wrap_q, wrap_d;
    logic [ROW_W-1:0] tgt_row_q, tgt_row_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [8:0]       instr_q, instr_d;
    logic             valid_q, valid_d;

    logic             fifo_full, fifo_empty, fifo_pop;
    logic [7:0]       fifo_rdata;
    logic             accept, is_print, is_lf, is_cr, is_ff, drop, at_wrap;
    logic [ROW_W-1:0] next_row;

    lcd_char_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .push   (char_valid),
        .wdata  (char),
        .pop    (fifo_pop),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    function automatic logic [7:0] fold_case(input logic [7:0] b);
`ifdef LCD_CASE_FOLD_EN
        return (b >= 8'h61 && b <= 8'h7A) ? (b - 8'h20) : b;
`else
        return b;
`endif
    endfunction

    function automatic logic [8:0] data_write(input logic [7:0] b);
        logic [8:0] w;
        w         = {1'b0, fold_case(b)};
        w[RS_BIT] = 1'b1;
        return w;
    endfunction

    function automatic logic [8:0] set_addr(input logic [ROW_W-1:0] r);
        return LCD_CMD_SET_DDRAM | {2'b00, ddram_addr(32'(r), COLS)};
    endfunction

    assign accept   = valid_q && instr_ready;
    assign is_print = (byte_q >= PRINT_MIN) && (byte_q <= PRINT_MAX);
    assign is_lf    = (byte_q == ASCII_LF);
    assign is_cr    = (byte_q == ASCII_CR);
    assign is_ff    = (byte_q == ASCII_FF);
    assign drop     = have_q && !(is_print || is_lf || is_cr || is_ff);
    assign at_wrap  = (col_q == COL_W'(COLS));
    assign next_row = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);

    // byte_q is a one-entry holding stage: refilled while the previous
    // instruction retires so steady-state cost stays at two cycles per byte.
    assign fifo_pop = !fifo_empty &&
                      (((state_q == ST_IDLE) && (!have_q || drop)) ||
                       (accept && (state_d == ST_IDLE)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            byte_q    <= '0;
            have_q    <= 1'b0;
            wrap_q    <= 1'b0;
            tgt_row_q <= '0;
            row_q     <= '0;
            col_q     <= '0;
            instr_q   <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            byte_q    <= byte_d;
            have_q    <= have_d;
            wrap_q    <= wrap_d;
            tgt_row_q <= tgt_row_d;
            row_q     <= row_d;
            col_q     <= col_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (have_q) begin
                    if (is_print)            state_d = at_wrap ? ST_ADDR : ST_CHAR;
                    else if (is_lf || is_cr) state_d = ST_ADDR;
                    else if (is_ff)          state_d = ST_CMD;
                end
            end
            ST_ADDR:         if (accept) state_d = wrap_q ? ST_CHAR : ST_IDLE;
            ST_CHAR, ST_CMD: if (accept) state_d = ST_IDLE;
            default:         state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        byte_d    = byte_q;
        have_d    = have_q;
        wrap_d    = wrap_q;
        tgt_row_d = tgt_row_q;
        row_d     = row_q;
        col_d     = col_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (have_q) begin
                    have_d = 1'b0;
                    wrap_d = 1'b0;
                    if (is_print && at_wrap) begin
                        tgt_row_d = next_row;
                        wrap_d    = 1'b1;
                        instr_d   = set_addr(next_row);
                        valid_d   = 1'b1;
                    end else if (is_print) begin
                        instr_d = data_write(byte_q);
                        valid_d = 1'b1;
                    end else if (is_lf) begin
                        tgt_row_d = next_row;
                        instr_d   = set_addr(next_row);
                        valid_d   = 1'b1;
                    end else if (is_cr) begin
                        tgt_row_d = row_q;
                        instr_d   = set_addr(row_q);
                        valid_d   = 1'b1;
                    end else if (is_ff) begin
                        instr_d = LCD_CMD_CLEAR;
                        valid_d = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                if (accept) begin
                    row_d = tgt_row_q;
                    col_d = '0;
                    if (wrap_q) instr_d = data_write(byte_q);
                    else        valid_d = 1'b0;
                end
            end
            ST_CHAR: begin
                if (accept) begin
                    col_d   = col_q + COL_W'(1);
                    valid_d = 1'b0;
                end
            end
            ST_CMD: begin
                if (accept) begin
                    row_d   = '0;
                    col_d   = '0;
                    valid_d = 1'b0;
                end
            end
            default: ;
        endcase
        if (fifo_pop) begin
            byte_d = fifo_rdata;
            have_d = 1'b1;
        end
    end

    assign char_ready  = !fifo_full;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign cur_row     = row_q;
    assign cur_col     = col_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_char_stream.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_lcd_char_stream: two panel geometries (16x2, 20x4) against a cursor model.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_lcd_char_stream;

    typedef struct {
        logic [8:0] ins;
        int         row;
        int         col;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       cv0, cv1, rdy0, rdy1;
    logic [7:0] cb0, cb1;
    logic       crdy0, crdy1, iv0, iv1;
    logic [8:0] ins0, ins1;
    logic [0:0] row0;
    logic [1:0] row1;
    logic [4:0] col0, col1;

    lcd_char_stream #(.COLS(16), .ROWS(2), .FIFO_DEPTH(8)) dut0 (
        .clk(clk), .reset_n(reset_n), .char_valid(cv0), .char(cb0), .char_ready(crdy0),
        .instr_valid(iv0), .instr(ins0), .instr_ready(rdy0), .cur_row(row0), .cur_col(col0)
    );

    lcd_char_stream #(.COLS(20), .ROWS(4), .FIFO_DEPTH(8)) dut1 (
        .clk(clk), .reset_n(reset_n), .char_valid(cv1), .char(cb1), .char_ready(crdy1),
        .instr_valid(iv1), .instr(ins1), .instr_ready(rdy1), .cur_row(row1), .cur_col(col1)
    );

    int   total = 0;
    int   bad   = 0;
    int   acc_cnt = 0;
    exp_t expq[$];
    int   mrow[2];
    int   mcol[2];
    logic hold_pend = 1'b0;
    logic [8:0] hold_val = '0;
    logic [8:0] last_ins = '0;

    function automatic int cols_of(input int u); return (u == 0) ? 16 : 20; endfunction
    function automatic int rows_of(input int u); return (u == 0) ? 2 : 4;   endfunction
    function automatic logic get_iv(input int u);   return (u == 0) ? iv0 : iv1;     endfunction
    function automatic logic get_crdy(input int u); return (u == 0) ? crdy0 : crdy1; endfunction
    function automatic logic [8:0] get_ins(input int u); return (u == 0) ? ins0 : ins1; endfunction
    function automatic int get_row(input int u); return (u == 0) ? int'(row0) : int'(row1); endfunction
    function automatic int get_col(input int u); return (u == 0) ? int'(col0) : int'(col1); endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mfold(input logic [7:0] b);
`ifdef LCD_CASE_FOLD_EN
        if (b >= 8'h61 && b <= 8'h7A) return b - 8'd32;
`endif
        return b;
    endfunction

    function automatic logic [8:0] maddr(input int u, input int r, input int c);
        return 9'(128 + (r % 2) * 64 + (r / 2) * cols_of(u) + c);
    endfunction

    // Reference: each accepted byte expands into the instructions it must produce,
    // tagged with the cursor position expected once that instruction is taken.
    task automatic model_byte(input int u, input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            if (mcol[u] == cols_of(u)) begin
                mrow[u] = (mrow[u] + 1) % rows_of(u);
                mcol[u] = 0;
                expq.push_back('{maddr(u, mrow[u], 0), mrow[u], 0});
            end
            mcol[u] = mcol[u] + 1;
            expq.push_back('{{1'b1, mfold(b)}, mrow[u], mcol[u]});
        end else if (b == 8'h0A) begin
            mrow[u] = (mrow[u] + 1) % rows_of(u);
            mcol[u] = 0;
            expq.push_back('{maddr(u, mrow[u], 0), mrow[u], 0});
        end else if (b == 8'h0D) begin
            mcol[u] = 0;
            expq.push_back('{maddr(u, mrow[u], 0), mrow[u], 0});
        end else if (b == 8'h0C) begin
            mrow[u] = 0;
            mcol[u] = 0;
            expq.push_back('{9'h001, 0, 0});
        end
    endtask

    task automatic drive(input int u, input logic v, input logic [7:0] b, input logic r);
        cv0 = (u == 0) ? v : 1'b0;  cb0 = (u == 0) ? b : 8'h00;  rdy0 = (u == 0) ? r : 1'b0;
        cv1 = (u == 1) ? v : 1'b0;  cb1 = (u == 1) ? b : 8'h00;  rdy1 = (u == 1) ? r : 1'b0;
    endtask

    // Called at posedge+1; observes, then advances exactly one clock.
    task automatic cycle(input int u, input logic v, input logic [7:0] b, input logic r,
                         output logic pushed);
        logic oacc;
        exp_t e;
        e = '{9'h1FF, -1, -1};
        drive(u, v, b, r);
        if (hold_pend) begin
            chk("hold_valid", 32'(get_iv(u)), 32'd1);
            chk("hold_instr", 32'(get_ins(u)), 32'(hold_val));
        end
        pushed = v && get_crdy(u);
        oacc   = get_iv(u) && r;
        if (pushed) model_byte(u, b);
        if (oacc) begin
            if (expq.size() > 0) e = expq.pop_front();
            chk("instr", 32'(get_ins(u)), 32'(e.ins));
            last_ins = get_ins(u);
            acc_cnt++;
        end
        hold_pend = get_iv(u) && !r;
        hold_val  = get_ins(u);
        @(posedge clk);
        #1;
        if (oacc) begin
            chk("cur_row", 32'(get_row(u)), 32'(e.row));
            chk("cur_col", 32'(get_col(u)), 32'(e.col));
        end
    endtask

    task automatic send(input int u, input logic [7:0] b, input logic r);
        logic p;
        p = 1'b0;
        for (int n = 0; n < 40 && !p; n++) cycle(u, 1'b1, b, r, p);
        chk("push_accepted", 32'(p), 32'd1);
    endtask

    task automatic drain(input int u);
        logic p;
        int   n;
        n = 0;
        while ((expq.size() != 0 || get_iv(u)) && n < 300) begin
            cycle(u, 1'b0, 8'h00, 1'b1, p);
            n++;
        end
        repeat (4) cycle(u, 1'b0, 8'h00, 1'b1, p);
        chk("drain_left", 32'(expq.size()), 32'd0);
        chk("drain_row", 32'(get_row(u)), 32'(mrow[u]));
        chk("drain_col", 32'(get_col(u)), 32'(mcol[u]));
    endtask

    function automatic logic [7:0] rand_byte();
        int s;
        s = $urandom_range(0, 19);
        if (s < 15)       return 8'($urandom_range(32, 126));
        else if (s < 17)  return 8'h0A;
        else if (s == 17) return 8'h0D;
        else if (s == 18) return 8'h0C;
        else if ($urandom_range(0, 1) == 0) return 8'($urandom_range(0, 31));
        else              return 8'($urandom_range(127, 255));
    endfunction

    initial begin
        logic p;
        int   n, base;

        mrow = '{0, 0};
        mcol = '{0, 0};
        reset_n = 1'b0;
        drive(0, 1'b0, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        for (int u = 0; u < 2; u++) begin
            chk("rst_valid", 32'(get_iv(u)), 32'd0);
            chk("rst_instr", 32'(get_ins(u)), 32'd0);
            chk("rst_ready", 32'(get_crdy(u)), 32'd1);
            chk("rst_row", 32'(get_row(u)), 32'd0);
            chk("rst_col", 32'(get_col(u)), 32'd0);
        end

        // Latency: accepted at edge k, valid visible after edge k+2.
        cycle(0, 1'b1, 8'h61, 1'b1, p);
        chk("lat_push", 32'(p), 32'd1);
        chk("lat_k", 32'(iv0), 32'd0);
        cycle(0, 1'b0, 8'h00, 1'b1, p);
        chk("lat_k1", 32'(iv0), 32'd0);
        cycle(0, 1'b0, 8'h00, 1'b1, p);
        chk("lat_k2", 32'(iv0), 32'd1);
`ifdef LCD_CASE_FOLD_EN
        chk("lat_instr", 32'(ins0), 32'h141);
`else
        chk("lat_instr", 32'(ins0), 32'h161);
`endif
        drain(0);
        chk("a_cursor", 32'(get_col(0)), 32'd1);

        // Deferred wrap across 17 characters.
        send(0, 8'h0C, 1'b1);
        drain(0);
        base = acc_cnt;
        for (int i = 0; i < 17; i++) send(0, 8'h58, 1'b1);
        drain(0);
        chk("wrap_count", 32'(acc_cnt - base), 32'd18);
        chk("wrap_row", 32'(get_row(0)), 32'd1);
        chk("wrap_col", 32'(get_col(0)), 32'd1);

        // Back-pressure: one instruction stalled, FIFO fills to depth.
        send(0, 8'h50, 1'b0);
        for (int i = 0; i < 10 && !iv0; i++) cycle(0, 1'b0, 8'h00, 1'b0, p);
        chk("bp_valid", 32'(iv0), 32'd1);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(0, (n < 10), 8'h30 + 8'(n), 1'b0, p);
            if (p) n++;
        end
        chk("bp_accepted", 32'(n), 32'd8);
        chk("bp_char_ready", 32'(crdy0), 32'd0);
        drain(0);

        // LF / CR / FF from a mid-line cursor.
        send(0, 8'h0C, 1'b1);
        send(0, 8'h0A, 1'b1);
        for (int i = 0; i < 5; i++) send(0, 8'h4B, 1'b1);
        drain(0);
        chk("pos_row", 32'(get_row(0)), 32'd1);
        chk("pos_col", 32'(get_col(0)), 32'd5);
        send(0, 8'h0A, 1'b1);
        drain(0);
        chk("lf_instr", 32'(last_ins), 32'h080);
        chk("lf_col", 32'(get_col(0)), 32'd0);
        send(0, 8'h41, 1'b1);
        send(0, 8'h42, 1'b1);
        send(0, 8'h0D, 1'b1);
        drain(0);
        chk("cr_instr", 32'(last_ins), 32'h080);
        send(0, 8'h0C, 1'b1);
        drain(0);
        chk("ff_instr", 32'(last_ins), 32'h001);

        // Dropped control bytes.
        send(0, 8'h41, 1'b1);
        drain(0);
        base = acc_cnt;
        send(0, 8'h07, 1'b1);
        send(0, 8'h00, 1'b1);
        drain(0);
        chk("drop_count", 32'(acc_cnt - base), 32'd0);
        chk("drop_col", 32'(get_col(0)), 32'd1);
        send(0, 8'h5A, 1'b1);
        drain(0);
        chk("z_instr", 32'(last_ins), 32'h15A);

        // 20x4 panel: row addressing through all four rows.
        base = acc_cnt;
        for (int i = 0; i < 3; i++) send(1, 8'h0A, 1'b1);
        drain(1);
        chk("r4_count", 32'(acc_cnt - base), 32'd3);
        chk("r4_last", 32'(last_ins), 32'h0D4);
        chk("r4_row", 32'(get_row(1)), 32'd3);

        // Asynchronous reset with a pending instruction and queued bytes.
        send(1, 8'h51, 1'b0);
        send(1, 8'h52, 1'b0);
        send(1, 8'h53, 1'b0);
        for (int i = 0; i < 10 && !iv1; i++) cycle(1, 1'b0, 8'h00, 1'b0, p);
        chk("prerst_valid", 32'(iv1), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(iv1), 32'd0);
        chk("arst_ready", 32'(crdy1), 32'd1);
        chk("arst_row", 32'(get_row(1)), 32'd0);
        chk("arst_col", 32'(get_col(1)), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        expq.delete();
        mrow = '{0, 0};
        mcol = '{0, 0};
        hold_pend = 1'b0;
        drain(1);

        // Randomised traffic on both geometries.
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 400; i++)
                cycle(u, ($urandom_range(0, 2) != 0), rand_byte(), ($urandom_range(0, 3) != 0), p);
            drain(u);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
